// File: rtl/rec_pkg.sv
// Shared encodings for the recorder mode controller and its SRAM access sequencer.
package rec_pkg;

    localparam int REC_ADDR_W = 18;
    localparam int REC_DATA_W = 16;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'b00,
        MODE_RECORD = 2'b01,
        MODE_PLAY   = 2'b10,
        MODE_PAUSE  = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        A_IDLE = 2'b00,
        A_WR   = 2'b01,
        A_RD   = 2'b10
    } acc_state_t;

    // Button command after priority resolution; held while the sequencer is busy.
    typedef enum logic [1:0] {
        CMD_NONE   = 2'b00,
        CMD_STOP   = 2'b01,
        CMD_RECORD = 2'b10,
        CMD_PLAY   = 2'b11
    } cmd_t;

endpackage

// File: rtl/sram_access_seq.sv
// SRAM access sequencer: one pending slot per requester, fixed-length strobes,
// read capture and silence replies for reads made outside playback.
module sram_access_seq
    import rec_pkg::*;
#(
    parameter int ADDR_W   = REC_ADDR_W,
    parameter int DATA_W   = REC_DATA_W,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_allow,
    input  logic              rd_allow,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] ptr,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_en,
    output logic              sram_we,
    output logic              busy,
    output logic              done,
    output logic              done_wr,
    output logic              overrun
);

    localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYC - 1);

    acc_state_t        acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              wr_pend_q, rd_pend_q;
    logic [DATA_W-1:0] wdata_pend_q, wdata_q, rd_data_q;
    logic              rd_valid_q;

    logic wr_acc, rd_acc, rd_sil, wr_busy, rd_busy;
    logic wr_new, rd_new, wr_avail, rd_avail, start_wr, start_rd, last;

    assign wr_acc   = wr_req && wr_allow;
    assign rd_acc   = rd_req && rd_allow;
    assign rd_sil   = rd_req && !rd_allow;
    assign wr_busy  = wr_pend_q || (acc_q == A_WR);
    assign rd_busy  = rd_pend_q || (acc_q == A_RD);
    assign wr_new   = wr_acc && !wr_busy;
    assign rd_new   = rd_acc && !rd_busy;
    assign wr_avail = wr_pend_q || wr_new;
    assign rd_avail = rd_pend_q || rd_new;
    // Writes win when both slots are ready.
    assign start_wr = (acc_q == A_IDLE) && wr_avail;
    assign start_rd = (acc_q == A_IDLE) && !wr_avail && rd_avail;
    assign last     = (acc_q != A_IDLE) && (cnt_q == LAST_CNT);

    always_ff @(posedge clk) begin
        if (reset) acc_q <= A_IDLE;
        else       acc_q <= acc_d;
    end

    always_comb begin
        acc_d = acc_q;
        case (acc_q)
            A_IDLE: begin
                if (start_wr)      acc_d = A_WR;
                else if (start_rd) acc_d = A_RD;
            end
            A_WR, A_RD: if (last) acc_d = A_IDLE;
            default: acc_d = A_IDLE;
        endcase
    end

    always_comb begin
        sram_en    = (acc_q != A_IDLE);
        sram_we    = (acc_q == A_WR);
        done       = last;
        done_wr    = (acc_q == A_WR);
        overrun    = (wr_acc && wr_busy) || (rd_acc && rd_busy);
        busy       = (acc_q != A_IDLE) || wr_pend_q || rd_pend_q || wr_new || rd_new;
        sram_addr  = ptr;
        sram_wdata = wdata_q;
        rd_data    = rd_data_q;
        rd_valid   = rd_valid_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            wr_pend_q    <= 1'b0;
            rd_pend_q    <= 1'b0;
            wdata_pend_q <= '0;
            wdata_q      <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            if (rd_sil) begin
                rd_valid_q <= 1'b1;
                rd_data_q  <= '0;
            end
            if (acc_q == A_IDLE) cnt_q <= '0;
            else                 cnt_q <= cnt_q + CNT_W'(1);
            if (start_wr) begin
                wdata_q   <= wr_pend_q ? wdata_pend_q : wr_data;
                wr_pend_q <= 1'b0;
            end else if (wr_new) begin
                wr_pend_q    <= 1'b1;
                wdata_pend_q <= wr_data;
            end
            if (start_rd)    rd_pend_q <= 1'b0;
            else if (rd_new) rd_pend_q <= 1'b1;
            if (last && (acc_q == A_RD)) begin
                rd_valid_q <= 1'b1;
                rd_data_q  <= sram_rdata;
            end
        end
    end

endmodule

// File: rtl/rec_ctrl.sv
// Recorder mode controller: button edge detection, record/play/pause FSM,
// SRAM address pointer and recording length.
module rec_ctrl
    import rec_pkg::*;
#(
    parameter int ADDR_W   = REC_ADDR_W,
    parameter int DATA_W   = REC_DATA_W,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_btn,
    input  logic              record_btn,
    input  logic              stop_btn,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              sram_en,
    output logic              sram_we,
    output logic [1:0]        state_o,
    output logic [ADDR_W-1:0] end_addr_o,
    output logic              full_o,
    output logic              overrun_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    mode_t             mode_q, mode_d;
    cmd_t              cmd_q, cmd_d, cmd_new, cmd_eff;
    logic              play_q, record_q, stop_q;
    logic [ADDR_W-1:0] ptr_q, end_q;
    logic              full_q, overrun_q;
    logic              ptr_clr, end_load, hit_full, clr_flags;
    logic              wr_allow, rd_allow;
    logic              seq_busy, seq_done, seq_done_wr, seq_overrun;

    sram_access_seq #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .WAIT_CYC(WAIT_CYC)
    ) u_seq (
        .clk       (clk),
        .reset     (reset),
        .wr_allow  (wr_allow),
        .rd_allow  (rd_allow),
        .wr_req    (wr_req),
        .wr_data   (wr_data),
        .rd_req    (rd_req),
        .ptr       (ptr_q),
        .sram_rdata(sram_rdata),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .sram_addr (sram_addr),
        .sram_wdata(sram_wdata),
        .sram_en   (sram_en),
        .sram_we   (sram_we),
        .busy      (seq_busy),
        .done      (seq_done),
        .done_wr   (seq_done_wr),
        .overrun   (seq_overrun)
    );

    // A fresh edge overrides a command still waiting for the sequencer.
    always_comb begin
        if (stop_btn && !stop_q)            cmd_new = CMD_STOP;
        else if (record_btn && !record_q)   cmd_new = CMD_RECORD;
        else if (play_btn && !play_q)       cmd_new = CMD_PLAY;
        else                                cmd_new = CMD_NONE;
        cmd_eff = (cmd_new != CMD_NONE) ? cmd_new : cmd_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= MODE_IDLE;
            cmd_q  <= CMD_NONE;
        end else begin
            mode_q <= mode_d;
            cmd_q  <= cmd_d;
        end
    end

    always_comb begin
        mode_d    = mode_q;
        cmd_d     = CMD_NONE;
        ptr_clr   = 1'b0;
        end_load  = 1'b0;
        hit_full  = 1'b0;
        clr_flags = 1'b0;
        if (seq_busy) begin
            cmd_d = cmd_eff;
            if (seq_done && seq_done_wr && (mode_q == MODE_RECORD) && (ptr_q == LAST_ADDR)) begin
                mode_d   = MODE_IDLE;
                hit_full = 1'b1;
            end
            if (seq_done && !seq_done_wr && (mode_q == MODE_PLAY) &&
                (({1'b0, ptr_q} + (ADDR_W+1)'(1)) == {1'b0, end_q}))
                mode_d = MODE_IDLE;
        end else begin
            case (mode_q)
                MODE_IDLE: begin
                    if (cmd_eff == CMD_RECORD) begin
                        mode_d    = MODE_RECORD;
                        ptr_clr   = 1'b1;
                        clr_flags = 1'b1;
                    end else if ((cmd_eff == CMD_PLAY) && (end_q != '0)) begin
                        mode_d  = MODE_PLAY;
                        ptr_clr = 1'b1;
                    end
                end
                MODE_RECORD: begin
                    if ((cmd_eff == CMD_STOP) || (cmd_eff == CMD_RECORD)) begin
                        mode_d   = MODE_IDLE;
                        end_load = 1'b1;
                    end
                end
                MODE_PLAY: begin
                    if (cmd_eff == CMD_STOP)      mode_d = MODE_IDLE;
                    else if (cmd_eff == CMD_PLAY) mode_d = MODE_PAUSE;
                end
                MODE_PAUSE: begin
                    if (cmd_eff == CMD_STOP)      mode_d = MODE_IDLE;
                    else if (cmd_eff == CMD_PLAY) mode_d = MODE_PLAY;
                end
                default: mode_d = MODE_IDLE;
            endcase
        end
    end

    always_comb begin
        state_o    = mode_q;
        wr_allow   = (mode_q == MODE_RECORD);
        rd_allow   = (mode_q == MODE_PLAY);
        end_addr_o = end_q;
        full_o     = full_q;
        overrun_o  = overrun_q;
    end

    // The pointer saturates at the last address so a full memory never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            play_q    <= 1'b0;
            record_q  <= 1'b0;
            stop_q    <= 1'b0;
            ptr_q     <= '0;
            end_q     <= '0;
            full_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            play_q   <= play_btn;
            record_q <= record_btn;
            stop_q   <= stop_btn;
            if (ptr_clr)                              ptr_q <= '0;
            else if (seq_done && (ptr_q != LAST_ADDR)) ptr_q <= ptr_q + ADDR_W'(1);
            if (hit_full)      end_q <= LAST_ADDR;
            else if (end_load) end_q <= ptr_q;
            if (clr_flags) begin
                full_q    <= 1'b0;
                overrun_q <= 1'b0;
            end else begin
                if (hit_full)    full_q    <= 1'b1;
                if (seq_overrun) overrun_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rec_ctrl.sv
// Self-checking bench for rec_ctrl with a 16-word SRAM model: cycle-by-cycle
// vector table for record/play/pause, then hand sequences for full memory and reset mid-access.
module tb_rec_ctrl;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;
    localparam int NVEC   = 41;

    logic              clk = 1'b0;
    logic              reset;
    logic              play_btn, record_btn, stop_btn;
    logic              wr_req, rd_req;
    logic [DATA_W-1:0] wr_data, rd_data, sram_wdata, sram_rdata;
    logic              rd_valid, sram_en, sram_we, full_o, overrun_o;
    logic [ADDR_W-1:0] sram_addr, end_addr_o;
    logic [1:0]        state_o;

    logic [DATA_W-1:0] mem [16];

    int vec_count  = 0;
    int miss_count = 0;

    typedef struct packed {
        logic [1:0]  state;
        logic        en;
        logic        we;
        logic [3:0]  addr;
        logic        rv;
        logic [15:0] rdat;
        logic [15:0] wdat;
        logic [3:0]  endp;
        logic        full;
        logic        ovr;
    } outs_t;

    typedef struct packed {
        logic        rst;
        logic        pl;
        logic        rc;
        logic        st;
        logic        wr;
        logic [15:0] wd;
        logic        rd;
        outs_t       exp;
    } vec_t;

    vec_t tbl [NVEC];

    rec_ctrl #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .WAIT_CYC(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .play_btn  (play_btn),
        .record_btn(record_btn),
        .stop_btn  (stop_btn),
        .wr_req    (wr_req),
        .wr_data   (wr_data),
        .rd_req    (rd_req),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .sram_addr (sram_addr),
        .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata),
        .sram_en   (sram_en),
        .sram_we   (sram_we),
        .state_o   (state_o),
        .end_addr_o(end_addr_o),
        .full_o    (full_o),
        .overrun_o (overrun_o)
    );

    always #5 clk = ~clk;

    // Asynchronous-read SRAM model written on the clock edge while strobed for write.
    always @(posedge clk) begin
        if (sram_en && sram_we) mem[sram_addr] <= sram_wdata;
    end
    assign sram_rdata = mem[sram_addr];

    function automatic outs_t o(input logic [1:0] s, input logic [2:0] en_we_rv, input logic [3:0] a,
                                input logic [15:0] rdt, input logic [15:0] wdt, input logic [3:0] e,
                                input logic [1:0] full_ovr);
        outs_t r;
        r.state = s;
        r.en    = en_we_rv[2];
        r.we    = en_we_rv[1];
        r.rv    = en_we_rv[0];
        r.addr  = a;
        r.rdat  = rdt;
        r.wdat  = wdt;
        r.endp  = e;
        r.full  = full_ovr[1];
        r.ovr   = full_ovr[0];
        return r;
    endfunction

    // ctl = {reset, play, record, stop, wr_req}
    function automatic vec_t mk(input logic [4:0] ctl, input logic [15:0] wd, input logic rd, input outs_t e);
        vec_t v;
        v.rst = ctl[4];
        v.pl  = ctl[3];
        v.rc  = ctl[2];
        v.st  = ctl[1];
        v.wr  = ctl[0];
        v.wd  = wd;
        v.rd  = rd;
        v.exp = e;
        return v;
    endfunction

    function automatic outs_t getOutputs();
        outs_t r;
        r.state = state_o;
        r.en    = sram_en;
        r.we    = sram_we;
        r.addr  = sram_addr;
        r.rv    = rd_valid;
        r.rdat  = rd_data;
        r.wdat  = sram_wdata;
        r.endp  = end_addr_o;
        r.full  = full_o;
        r.ovr   = overrun_o;
        return r;
    endfunction

    function automatic string fmt(input outs_t v);
        return $sformatf("state=%0d en=%b we=%b addr=%h rv=%b rdat=%h wdat=%h end=%h full=%b ovr=%b",
                         v.state, v.en, v.we, v.addr, v.rv, v.rdat, v.wdat, v.endp, v.full, v.ovr);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        reset      = v.rst;
        play_btn   = v.pl;
        record_btn = v.rc;
        stop_btn   = v.st;
        wr_req     = v.wr;
        wr_data    = v.wd;
        rd_req     = v.rd;
    endtask

    task automatic checkOutput(input string name, input outs_t act, input outs_t exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got {%s} expected {%s}", name, fmt(act), fmt(exp));
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // Record three samples, stop while the last write is still in flight.
        tbl[0]  = mk(5'b10000, 16'h0000, 1'b0, o(2'd0, 3'b000, 4'h0, 16'h0000, 16'h0000, 4'h0, 2'b00));
        tbl[1]  = mk(5'b00100, 16'h0000, 1'b0, o(2'd0, 3'b000, 4'h0, 16'h0000, 16'h0000, 4'h0, 2'b00));
        tbl[2]  = mk(5'b00001, 16'h1111, 1'b0, o(2'd1, 3'b000, 4'h0, 16'h0000, 16'h0000, 4'h0, 2'b00));
        tbl[3]  = mk(5'b00000, 16'h0000, 1'b0, o(2'd1, 3'b110, 4'h0, 16'h0000, 16'h1111, 4'h0, 2'b00));
        tbl[4]  = mk(5'b00000, 16'h0000, 1'b0, o(2'd1, 3'b110, 4'h0, 16'h0000, 16'h1111, 4'h0, 2'b00));
        tbl[5]  = mk(5'b00000, 16'h0000, 1'b0, o(2'd1, 3'b000, 4'h1, 16'h0000, 16'h1111, 4'h0, 2'b00));
        tbl[6]  = mk(5'b00001, 16'h2222, 1'b0, o(2'd1, 3'b000, 4'h1, 16'h0000, 16'h1111, 4'h0, 2'b00));
        tbl[7]  = mk(5'b00000, 16'h0000, 1'b0, o(2'd1, 3'b110, 4'h1, 16'h0000, 16'h2222, 4'h0, 2'b00));
        tbl[8]  = mk(5'b00000, 16'h0000, 1'b0, o(2'd1, 3'b110, 4'h1, 16'h0000, 16'h2222, 4'h0, 2'b00));
        tbl[9]  = mk(5'b00000, 16'h0000, 1'b0, o(2'd1, 3'b000, 4'h2, 16'h0000, 16'h2222, 4'h0, 2'b00));
        tbl[10] = mk(5'b00001, 16'h3333, 1'b0, o(2'd1, 3'b000, 4'h2, 16'h0000, 16'h2222, 4'h0, 2'b00));
        tbl[11] = mk(5'b00000, 16'h0000, 1'b0, o(2'd1, 3'b110, 4'h2, 16'h0000, 16'h3333, 4'h0, 2'b00));
        tbl[12] = mk(5'b00010, 16'h0000, 1'b0, o(2'd1, 3'b110, 4'h2, 16'h0000, 16'h3333, 4'h0, 2'b00));
        tbl[13] = mk(5'b00000, 16'h0000, 1'b0, o(2'd1, 3'b000, 4'h3, 16'h0000, 16'h3333, 4'h0, 2'b00));
        tbl[14] = mk(5'b00000, 16'h0000, 1'b0, o(2'd0, 3'b000, 4'h3, 16'h0000, 16'h3333, 4'h3, 2'b00));
        // Play back: read, pause requested mid-read, silent read in pause, resume.
        tbl[15] = mk(5'b01000, 16'h0000, 1'b0, o(2'd0, 3'b000, 4'h3, 16'h0000, 16'h3333, 4'h3, 2'b00));
        tbl[16] = mk(5'b00000, 16'h0000, 1'b1, o(2'd2, 3'b000, 4'h0, 16'h0000, 16'h3333, 4'h3, 2'b00));
        tbl[17] = mk(5'b00000, 16'h0000, 1'b0, o(2'd2, 3'b100, 4'h0, 16'h0000, 16'h3333, 4'h3, 2'b00));
        tbl[18] = mk(5'b00000, 16'h0000, 1'b0, o(2'd2, 3'b100, 4'h0, 16'h0000, 16'h3333, 4'h3, 2'b00));
        tbl[19] = mk(5'b00000, 16'h0000, 1'b0, o(2'd2, 3'b001, 4'h1, 16'h1111, 16'h3333, 4'h3, 2'b00));
        tbl[20] = mk(5'b00000, 16'h0000, 1'b1, o(2'd2, 3'b000, 4'h1, 16'h1111, 16'h3333, 4'h3, 2'b00));
        tbl[21] = mk(5'b01000, 16'h0000, 1'b0, o(2'd2, 3'b100, 4'h1, 16'h1111, 16'h3333, 4'h3, 2'b00));
        tbl[22] = mk(5'b00000, 16'h0000, 1'b0, o(2'd2, 3'b100, 4'h1, 16'h1111, 16'h3333, 4'h3, 2'b00));
        tbl[23] = mk(5'b00000, 16'h0000, 1'b0, o(2'd2, 3'b001, 4'h2, 16'h2222, 16'h3333, 4'h3, 2'b00));
        tbl[24] = mk(5'b00000, 16'h0000, 1'b1, o(2'd3, 3'b000, 4'h2, 16'h2222, 16'h3333, 4'h3, 2'b00));
        tbl[25] = mk(5'b00000, 16'h0000, 1'b0, o(2'd3, 3'b001, 4'h2, 16'h0000, 16'h3333, 4'h3, 2'b00));
        tbl[26] = mk(5'b01000, 16'h0000, 1'b0, o(2'd3, 3'b000, 4'h2, 16'h0000, 16'h3333, 4'h3, 2'b00));
        tbl[27] = mk(5'b00000, 16'h0000, 1'b1, o(2'd2, 3'b000, 4'h2, 16'h0000, 16'h3333, 4'h3, 2'b00));
        tbl[28] = mk(5'b00000, 16'h0000, 1'b0, o(2'd2, 3'b100, 4'h2, 16'h0000, 16'h3333, 4'h3, 2'b00));
        tbl[29] = mk(5'b00000, 16'h0000, 1'b0, o(2'd2, 3'b100, 4'h2, 16'h0000, 16'h3333, 4'h3, 2'b00));
        tbl[30] = mk(5'b00000, 16'h0000, 1'b0, o(2'd0, 3'b001, 4'h3, 16'h3333, 16'h3333, 4'h3, 2'b00));
        tbl[31] = mk(5'b00000, 16'h0000, 1'b0, o(2'd0, 3'b000, 4'h3, 16'h3333, 16'h3333, 4'h3, 2'b00));
        // Simultaneous record+stop in IDLE resolves as stop, so nothing starts.
        tbl[32] = mk(5'b00110, 16'h0000, 1'b0, o(2'd0, 3'b000, 4'h3, 16'h3333, 16'h3333, 4'h3, 2'b00));
        tbl[33] = mk(5'b00000, 16'h0000, 1'b0, o(2'd0, 3'b000, 4'h3, 16'h3333, 16'h3333, 4'h3, 2'b00));
        // Back-to-back writes: the second is dropped and flags overrun.
        tbl[34] = mk(5'b00100, 16'h0000, 1'b0, o(2'd0, 3'b000, 4'h3, 16'h3333, 16'h3333, 4'h3, 2'b00));
        tbl[35] = mk(5'b00001, 16'hAAAA, 1'b0, o(2'd1, 3'b000, 4'h0, 16'h3333, 16'h3333, 4'h3, 2'b00));
        tbl[36] = mk(5'b00001, 16'hBBBB, 1'b0, o(2'd1, 3'b110, 4'h0, 16'h3333, 16'hAAAA, 4'h3, 2'b00));
        tbl[37] = mk(5'b00000, 16'h0000, 1'b0, o(2'd1, 3'b110, 4'h0, 16'h3333, 16'hAAAA, 4'h3, 2'b01));
        tbl[38] = mk(5'b00000, 16'h0000, 1'b0, o(2'd1, 3'b000, 4'h1, 16'h3333, 16'hAAAA, 4'h3, 2'b01));
        tbl[39] = mk(5'b00010, 16'h0000, 1'b0, o(2'd1, 3'b000, 4'h1, 16'h3333, 16'hAAAA, 4'h3, 2'b01));
        tbl[40] = mk(5'b00000, 16'h0000, 1'b0, o(2'd0, 3'b000, 4'h1, 16'h3333, 16'hAAAA, 4'h1, 2'b01));

        reset      = 1'b1;
        play_btn   = 1'b0;
        record_btn = 1'b0;
        stop_btn   = 1'b0;
        wr_req     = 1'b0;
        rd_req     = 1'b0;
        wr_data    = '0;
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(tbl[i]);
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i), getOutputs(), tbl[i].exp);
            tick();
        end

        // Fill all 16 words; the write at the last address ends the recording.
        record_btn = 1'b1;
        tick();
        record_btn = 1'b0;
        @(negedge clk);
        checkValue("rec_entry", 32'({state_o, full_o, overrun_o, sram_addr}), 32'({2'd1, 1'b0, 1'b0, 4'h0}));
        tick();
        for (int i = 0; i < 16; i++) begin
            wr_req  = 1'b1;
            wr_data = 16'hC000 + 16'(i);
            tick();
            wr_req = 1'b0;
            @(negedge clk);
            checkValue($sformatf("fill_wr%0d", i), 32'({sram_en, sram_we, sram_addr}),
                       32'({1'b1, 1'b1, 4'(i)}));
            tick();
            tick();
        end
        @(negedge clk);
        checkValue("full_stop", 32'({state_o, full_o, end_addr_o, sram_en}), 32'({2'd0, 1'b1, 4'hF, 1'b0}));
        tick();
        wr_req  = 1'b1;
        wr_data = 16'hEEEE;
        tick();
        wr_req = 1'b0;
        @(negedge clk);
        checkValue("wr17_a", 32'({sram_en, state_o}), 32'({1'b0, 2'd0}));
        tick();
        @(negedge clk);
        checkValue("wr17_b", 32'({sram_en, full_o}), 32'({1'b0, 1'b1}));
        tick();

        // Reset lands during the second enable cycle of a write.
        record_btn = 1'b1;
        tick();
        record_btn = 1'b0;
        wr_req     = 1'b1;
        wr_data    = 16'hDEAD;
        tick();
        wr_req = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        checkValue("rst_pre", 32'({sram_en, sram_we, sram_addr, end_addr_o}), 32'({1'b1, 1'b1, 4'h0, 4'hF}));
        tick();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid", getOutputs(), o(2'd0, 3'b000, 4'h0, 16'h0000, 16'h0000, 4'h0, 2'b00));
        tick();
        @(negedge clk);
        checkOutput("rst_after", getOutputs(), o(2'd0, 3'b000, 4'h0, 16'h0000, 16'h0000, 4'h0, 2'b00));

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule

// File: doc/rec_ctrl.md
Name: rec_ctrl

Overview:
Mode controller and SRAM access scheduler for the audio recorder. It turns debounced play/record/stop levels into a record/play/pause state machine and owns the single SRAM address pointer. It arbitrates the SRAM between ADC sample writes and DAC sample reads, and remembers the recording length. It sits between the debounce instances, the adc/dac sample engines and the sram pin driver.

Parameters:
ADDR_W, 18, SRAM word-address width; last address is 2^ADDR_W-1.
DATA_W, 16, sample/SRAM data width.
WAIT_CYC, 2, clk cycles each SRAM access holds sram_en (min 1).

Ports:
clk  in  1  system clock (12 MHz PLL output); all logic on its rising edge.
reset  in  1  synchronous, active-high reset.
play_btn  in  1  debounced play level; rising edge is the event.
record_btn  in  1  debounced record level; rising edge is the event.
stop_btn  in  1  debounced stop level; rising edge is the event.
wr_req  in  1  one-cycle pulse from adc: sample ready on wr_data.
wr_data  in  DATA_W  sample to store; valid with wr_req.
rd_req  in  1  one-cycle pulse from dac: next sample wanted.
rd_data  out  DATA_W  sample returned to dac; valid with rd_valid.
rd_valid  out  1  one-cycle pulse: rd_data valid.
sram_addr  out  ADDR_W  SRAM word address.
sram_wdata  out  DATA_W  SRAM write data.
sram_rdata  in  DATA_W  SRAM read data.
sram_en  out  1  access strobe (chip/output enable to sram driver).
sram_we  out  1  1 = write access, valid while sram_en=1.
state_o  out  2  mode: 00 IDLE, 01 RECORD, 10 PLAY, 11 PAUSE.
end_addr_o  out  ADDR_W  number of words recorded.
full_o  out  1  sticky: recording stopped because memory is full.
overrun_o  out  1  sticky: a request was dropped.

Behaviour:
- Reset (takes priority over everything, including mid-access): state IDLE, pointer 0, end_addr 0, all outputs 0, edge-detect history cleared. An access in flight is abandoned.
- Edge detect: event = level 1 now and 0 on the previous cycle. Simultaneous events resolve by priority stop > record > play; lower-priority events in the same cycle are discarded.
- Mode FSM; a transition waits until the access sequencer is idle:
  - IDLE + record -> RECORD: pointer=0, full_o=0, overrun_o=0.
  - IDLE + play with end_addr!=0 -> PLAY: pointer=0. play with end_addr=0 is ignored.
  - RECORD + stop or record -> IDLE: end_addr=pointer.
  - RECORD, write completes at address 2^ADDR_W-1 -> IDLE: end_addr=2^ADDR_W-1, full_o=1. The pointer never wraps.
  - PLAY + play -> PAUSE, pointer held. PAUSE + play -> PLAY, resumes at the held pointer.
  - PLAY or PAUSE + stop -> IDLE.
  - PLAY, read completes with pointer+1==end_addr -> IDLE.
  - record in PLAY/PAUSE, and play in RECORD, are ignored.
- Access sequencer (states A_IDLE, A_WR, A_RD):
  - wr_req is accepted only in RECORD; rd_req only in PLAY.
  - A request sampled at cycle t drives sram_en=1 on cycles t+1 .. t+WAIT_CYC, with sram_addr=pointer and sram_we=1 for writes. For writes, sram_wdata is latched from wr_data at t.
  - Read: sram_rdata is captured on the last enable cycle; rd_valid=1 and rd_data are driven at t+WAIT_CYC+1.
  - The pointer increments on the cycle after the last enable.
  - One pending slot per requester. A request arriving while the same requester already has one pending or in flight is dropped and sets overrun_o.
  - When both requesters are pending, the write is served first (cannot occur in practice: the modes are exclusive).
- rd_req outside PLAY (IDLE, PAUSE, RECORD): rd_valid pulses at t+1 with rd_data=0 (silence). No SRAM access is made.
- wr_req outside RECORD: ignored silently; overrun_o is not set.
- Outside an access: sram_en=0, sram_we=0, sram_addr holds the pointer.

Decomposition:
- Package rec_pkg:
  - mode encodings MODE_IDLE/RECORD/PLAY/PAUSE (2-bit);
  - access-state encodings A_IDLE/A_WR/A_RD;
  - default ADDR_W/DATA_W constants.
- Sub-module sram_access_seq: the pending slots, the WAIT_CYC counter, the SRAM strobes, read capture and a done/addr_inc pulse.
- rec_ctrl keeps the edge detectors, the mode FSM, the pointer and end_addr.

Test Plan:
- Reset, then record edge, then 3 wr_req pulses (data 0x1111, 0x2222, 0x3333) spaced 10 cycles apart, then stop -> writes go to addr 0,1,2, each with sram_en high for exactly 2 cycles; end_addr_o=3; state_o=00.
- Play after the recording above, then 3 rd_req (sram_rdata model returns stored values) -> rd_valid at t+3 carrying 0x1111, 0x2222, 0x3333; state_o returns to 00 after the third read.
- Play, 1 read, play (pause), rd_req, play, rd_req -> the read during PAUSE returns 0 at t+1 with no sram_en; the next read resumes at addr 1.
- ADDR_W=4, record and issue 16 writes -> the last write goes to addr 15; full_o=1, end_addr_o=15, state IDLE; a 17th wr_req makes no access.
- In RECORD, wr_req on two consecutive cycles -> the first is served, the second is dropped, overrun_o=1; record and stop edges in the same cycle resolve as stop.
- Assert reset during the 2nd enable cycle of a write -> next cycle sram_en=0, state_o=00, end_addr_o=0.
